perspective_correct: RTL and testbench

- Per-fragment perspective-correction stage between the attribute interpolator and the texture sampler.
- Takes interpolated 1/w, u/w and v/w in 16.16 signed fixed point.
- Drives the external reciprocal unit to obtain w, then multiplies to recover u = (u/w)·w and v = (v/w)·w.
- The reciprocal unit has no stall input, so this block owns all flow control: a credit counter plus an output FIFO.

---
 rtl/graphite_pkg.sv | 48 ++++
 rtl/persp_fifo.sv | 67 ++++++
 rtl/perspective_correct.sv | 165 ++++++++++++++++
 tb/tb_perspective_correct.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/graphite_pkg.sv
// graphite_pkg: shared fixed-point types and helpers for the graphite pixel pipe.
// Build option PERSP_SAT_EN adds rmul_sat, a saturating variant of rmul.
package graphite_pkg;

  localparam int FIXED_FRAC_BITS = 16;
  localparam int FIXED_W         = 32;

  typedef logic signed [FIXED_W-1:0] fixed_t;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    fixed_t      u;
    fixed_t      v;
  } persp_frag_t;

  // Full-precision signed product of two 16.16 values, still in 32.32 form
  function automatic logic signed [2*FIXED_W-1:0] fx_prod(input fixed_t a, input fixed_t b);
    logic signed [2*FIXED_W-1:0] a_w;
    logic signed [2*FIXED_W-1:0] b_w;
    a_w = {{FIXED_W{a[FIXED_W-1]}}, a};
    b_w = {{FIXED_W{b[FIXED_W-1]}}, b};
    return a_w * b_w;
  endfunction

  // 16.16 multiply: arithmetic shift back to 16.16, keep the low 32 bits
  function automatic fixed_t rmul(input fixed_t a, input fixed_t b);
    logic signed [2*FIXED_W-1:0] prod;
    prod = fx_prod(a, b);
    return prod[FIXED_FRAC_BITS +: FIXED_W];
  endfunction

`ifdef PERSP_SAT_EN
  // 16.16 multiply clamping to the representable range instead of wrapping.
  // The shifted product fits in 32 bits only when bits [63:47] are all equal.
  function automatic fixed_t rmul_sat(input fixed_t a, input fixed_t b);
    logic signed [2*FIXED_W-1:0] prod;
    prod = fx_prod(a, b);
    if (prod[2*FIXED_W-1 -: FIXED_W-FIXED_FRAC_BITS+1] !=
        {(FIXED_W-FIXED_FRAC_BITS+1){prod[2*FIXED_W-1]}}) begin
      return prod[2*FIXED_W-1] ? {1'b1, {(FIXED_W-1){1'b0}}}
                               : {1'b0, {(FIXED_W-1){1'b1}}};
    end
    return prod[FIXED_FRAC_BITS +: FIXED_W];
  endfunction
`endif

endpackage

// File: rtl/persp_fifo.sv
// persp_fifo: synchronous show-ahead FIFO of persp_frag_t. head always shows
// the oldest entry; storage is cleared on reset because it drives block outputs.
module persp_fifo
  import graphite_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n_i,
  input  logic              push,
  input  persp_frag_t       push_data,
  input  logic              pop,
  output persp_frag_t       head,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  persp_frag_t      mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage, zeroed on reset so the outputs come up at zero
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Upstream admission control must never let a write reach a full FIFO
  a_no_push_on_full: assert property (@(posedge clk) disable iff (!reset_n_i) push |-> !full);

endmodule

// File: rtl/perspective_correct.sv
// perspective_correct: per-fragment perspective correction between the
// attribute interpolator and the texture sampler. Sends 1/w to the external
// fixed-latency reciprocal unit, then recovers u = (u/w)*w and v = (v/w)*w.
// The reciprocal unit cannot stall, so the pipeline free-runs and admission is
// credit based: a fragment is taken only when the output FIFO can already hold
// everything in flight. Fragments with 1/w <= 0 produce u = v = 0.
// Build option: define PERSP_SAT_EN to saturate overflowing u/v products
// instead of truncating them to the low 32 bits.
// reset_n_i asserts asynchronously; its release must be synchronous to clk.
module perspective_correct
  import graphite_pkg::*;
#(
  parameter int RECIP_LATENCY = 1,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset_n_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [15:0] frag_x_i,
  input  logic [15:0] frag_y_i,
  input  logic [31:0] w_inv_i,
  input  logic [31:0] u_w_i,
  input  logic [31:0] v_w_i,
  output logic [31:0] recip_x_o,
  input  logic [31:0] recip_z_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [15:0] out_x_o,
  output logic [15:0] out_y_o,
  output logic [31:0] out_u_o,
  output logic [31:0] out_v_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W = $clog2(FIFO_DEPTH + RECIP_LATENCY + 3) + 1;
  localparam int LAST  = RECIP_LATENCY - 1;

  if (RECIP_LATENCY < 1) begin : g_latency_check
    $error("perspective_correct: RECIP_LATENCY (%0d) must be >= 1", RECIP_LATENCY);
  end
  if (FIFO_DEPTH < RECIP_LATENCY + 2) begin : g_depth_check
    $error("perspective_correct: FIFO_DEPTH (%0d) must be >= RECIP_LATENCY+2 (%0d)",
           FIFO_DEPTH, RECIP_LATENCY + 2);
  end

  // 16.16 product back in 16.16, wrapping or clamping depending on the build
  function automatic fixed_t fx_mul(input fixed_t a, input fixed_t b);
`ifdef PERSP_SAT_EN
    return rmul_sat(a, b);
`else
    return rmul(a, b);
`endif
  endfunction

  logic                     accept;
  logic                     vld_p0;
  logic [15:0]              x_p0;
  logic [15:0]              y_p0;
  fixed_t                   w_inv_p0;
  fixed_t                   u_w_p0;
  fixed_t                   v_w_p0;
  logic                     neg_p0;

  logic [RECIP_LATENCY-1:0] vld_p1;
  logic [RECIP_LATENCY-1:0] neg_p1;
  logic [15:0]              x_p1   [RECIP_LATENCY];
  logic [15:0]              y_p1   [RECIP_LATENCY];
  fixed_t                   u_w_p1 [RECIP_LATENCY];
  fixed_t                   v_w_p1 [RECIP_LATENCY];

  logic                     vld_p2;
  persp_frag_t              frag_p2;

  logic [CNT_W-1:0]         fifo_count;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     fifo_pop;
  persp_frag_t              fifo_head;
  logic [SUM_W-1:0]         inflight;

  assign accept    = in_valid_i && in_ready_o;
  assign neg_p0    = w_inv_p0[31] || (w_inv_p0 == '0);
  assign recip_x_o = vld_p0 ? w_inv_p0 : '0;

  // Valid bits for S0, the reciprocal delay line and the multiply stage
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      vld_p0 <= 1'b0;
      vld_p1 <= '0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p0    <= accept;
      vld_p1[0] <= vld_p0;
      for (int i = 1; i < RECIP_LATENCY; i++) vld_p1[i] <= vld_p1[i-1];
      vld_p2    <= vld_p1[LAST];
    end
  end

  // S0: capture the accepted fragment; its 1/w feeds the reciprocal unit
  always_ff @(posedge clk) begin
    if (accept) begin
      x_p0     <= frag_x_i;
      y_p0     <= frag_y_i;
      w_inv_p0 <= w_inv_i;
      u_w_p0   <= u_w_i;
      v_w_p0   <= v_w_i;
    end
  end

  // P1: delay line keeping fragment data aligned with the returning reciprocal
  always_ff @(posedge clk) begin
    x_p1[0]   <= x_p0;
    y_p1[0]   <= y_p0;
    u_w_p1[0] <= u_w_p0;
    v_w_p1[0] <= v_w_p0;
    neg_p1[0] <= neg_p0;
    for (int i = 1; i < RECIP_LATENCY; i++) begin
      x_p1[i]   <= x_p1[i-1];
      y_p1[i]   <= y_p1[i-1];
      u_w_p1[i] <= u_w_p1[i-1];
      v_w_p1[i] <= v_w_p1[i-1];
      neg_p1[i] <= neg_p1[i-1];
    end
  end

  // P2: multiply by w; fragments behind the eye or at infinity give zero
  always_ff @(posedge clk) begin
    frag_p2.x <= x_p1[LAST];
    frag_p2.y <= y_p1[LAST];
    frag_p2.u <= neg_p1[LAST] ? '0 : fx_mul(u_w_p1[LAST], recip_z_i);
    frag_p2.v <= neg_p1[LAST] ? '0 : fx_mul(v_w_p1[LAST], recip_z_i);
  end

  // Credits in use: every valid stage will land in the FIFO without stalling
  always_comb begin
    inflight = SUM_W'(vld_p0) + SUM_W'(vld_p2);
    for (int i = 0; i < RECIP_LATENCY; i++) inflight = inflight + SUM_W'(vld_p1[i]);
  end

  assign in_ready_o = !fifo_full &&
                      ((SUM_W'(fifo_count) + inflight) < SUM_W'(FIFO_DEPTH));

  assign fifo_pop    = out_valid_o && out_ready_i;
  assign out_valid_o = !fifo_empty;
  assign out_x_o     = fifo_head.x;
  assign out_y_o     = fifo_head.y;
  assign out_u_o     = fifo_head.u;
  assign out_v_o     = fifo_head.v;

  persp_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n_i (reset_n_i),
    .push      (vld_p2),
    .push_data (frag_p2),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_perspective_correct.sv
// tb_perspective_correct: directed bench for perspective_correct with a
// latency-1 reciprocal model (w = 2^32 / w_inv) and an output scoreboard.
module tb_perspective_correct;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] frag_x = '0;
  logic [15:0] frag_y = '0;
  logic [31:0] w_inv = '0;
  logic [31:0] u_w = '0;
  logic [31:0] v_w = '0;
  logic [31:0] recip_x;
  logic [31:0] recip_z = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_x;
  logic [15:0] out_y;
  logic [31:0] out_u;
  logic [31:0] out_v;

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [31:0] u;
    logic [31:0] v;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_in;
  exp_t mon_exp;

  always #5 clk = ~clk;

  perspective_correct #(
    .RECIP_LATENCY (1),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk         (clk),
    .reset_n_i   (reset_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .frag_x_i    (frag_x),
    .frag_y_i    (frag_y),
    .w_inv_i     (w_inv),
    .u_w_i       (u_w),
    .v_w_i       (v_w),
    .recip_x_o   (recip_x),
    .recip_z_i   (recip_z),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_x_o     (out_x),
    .out_y_o     (out_y),
    .out_u_o     (out_u),
    .out_v_o     (out_v)
  );

  function automatic logic [31:0] recip_fn(input logic [31:0] w);
    logic [63:0] q;
    if (w == 32'h0 || w[31]) return 32'h0001_0000;
    q = 64'h1_0000_0000 / {32'h0, w};
    return q[31:0];
  endfunction

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] w);
    longint p;
    longint s;
    if (w == 32'h0 || w[31]) return 32'h0;
    p = longint'($signed(a)) * longint'($signed(recip_fn(w)));
    s = p >>> 16;
`ifdef PERSP_SAT_EN
    if (s > 64'sd2147483647)  return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
`endif
    return s[31:0];
  endfunction

  // Reciprocal unit: one-cycle fixed latency, no handshake
  always @(posedge clk) recip_z <= recip_fn(recip_x);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: record accepted fragments, compare every popped output in order
  always @(negedge clk) begin
    if (reset_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 64'd1, 64'd0);
        end else begin
          mon_exp = exp_q.pop_front();
          check("sb_x", out_x, mon_exp.x);
          check("sb_y", out_y, mon_exp.y);
          check("sb_u", out_u, mon_exp.u);
          check("sb_v", out_v, mon_exp.v);
          n_out++;
        end
      end
      if (in_valid && in_ready) begin
        mon_in.x = frag_x;
        mon_in.y = frag_y;
        mon_in.u = ref_mul(u_w, w_inv);
        mon_in.v = ref_mul(v_w, w_inv);
        exp_q.push_back(mon_in);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] x, input logic [15:0] y,
                       input logic [31:0] w, input logic [31:0] u, input logic [31:0] v);
    in_valid = 1'b1;
    frag_x   = x;
    frag_y   = y;
    w_inv    = w;
    u_w      = u;
    v_w      = v;
  endtask

  // Present a fragment and return just after the edge that accepts it
  task automatic push_frag(input logic [15:0] x, input logic [15:0] y,
                           input logic [31:0] w, input logic [31:0] u, input logic [31:0] v);
    int budget;
    drive(x, y, w, u, v);
    budget = 0;
    while (!in_ready && budget < 50) begin
      tick();
      budget++;
    end
    check("accept_wait", in_ready, 1'b1);
    tick();
  endtask

  task automatic send(input logic [15:0] x, input logic [15:0] y,
                      input logic [31:0] w, input logic [31:0] u, input logic [31:0] v);
    push_frag(x, y, w, u, v);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int budget;
    budget = 0;
    while (!out_valid && budget < 20) begin
      tick();
      budget++;
    end
    check(tag, out_valid, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          n_acc;
    int          base;
    logic [31:0] rw;

    // Reset state, with a fragment offered that must not be taken
    drive(16'hAAAA, 16'h5555, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_recip_x",   recip_x,   32'h0);
    check("rst_out_x",     out_x,     16'h0);
    check("rst_out_y",     out_y,     16'h0);
    check("rst_out_u",     out_u,     32'h0);
    check("rst_out_v",     out_v,     32'h0);
    check("rst_in_ready",  in_ready,  1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst_no_accept", out_valid, 1'b0);
    end

    // Basic: w = 2.0, u/w = 3.0, v/w = -1.0
    out_ready = 1'b1;
    send(16'h0012, 16'h0034, 32'h0000_8000, 32'h0003_0000, 32'hFFFF_0000);
    check("basic_recip_x", recip_x, 32'h0000_8000);
    check("basic_lat0", out_valid, 1'b0);
    tick();
    check("basic_lat1", out_valid, 1'b0);
    tick();
    check("basic_lat2", out_valid, 1'b0);
    tick();
    check("basic_lat3", out_valid, 1'b1);
    check("basic_x", out_x, 16'h0012);
    check("basic_y", out_y, 16'h0034);
    check("basic_u", out_u, 32'h0006_0000);
    check("basic_v", out_v, 32'hFFFE_0000);
    tick();
    check("basic_popped", out_valid, 1'b0);
    repeat (2) tick();

    // Backpressure: consumer stalled, producer always valid
    out_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      drive(16'h0100 + 16'(n_acc), 16'h0200 + 16'(n_acc), 32'h0001_0000,
            32'h0001_0000 * (n_acc + 1), 32'hFFFF_0000 - 32'(n_acc));
      if (in_ready) n_acc++;
      tick();
    end
    in_valid = 1'b0;
    check("bp_accepts",  n_acc,     4);
    check("bp_ready",    in_ready,  1'b0);
    check("bp_valid",    out_valid, 1'b1);
    out_ready = 1'b1;
    base = n_out;
    repeat (8) tick();
    check("bp_drained",  n_out - base,  4);
    check("bp_q_empty",  exp_q.size(),  0);
    check("bp_ready_up", in_ready,      1'b1);

    // Streaming random fragments
    base = n_out;
    for (int i = 0; i < 100; i++) begin
      rw = $urandom_range(32'h00FF_FFFF, 32'h0000_0100);
      if (i % 13 == 7) rw = rw | 32'h8000_0000;
      if (i % 29 == 3) rw = 32'h0;
      push_frag(16'(i), 16'(~i), rw, $urandom, $urandom);
    end
    in_valid = 1'b0;
    repeat (10) tick();
    check("stream_count",   n_out - base, 100);
    check("stream_q_empty", exp_q.size(), 0);

    // Invalid w: negative and zero 1/w
    send(16'h0001, 16'h0002, 32'hFFFF_0000, 32'h0001_0000, 32'h0002_0000);
    check("neg_recip_x", recip_x, 32'hFFFF_0000);
    wait_out("neg_wait");
    check("neg_u", out_u, 32'h0);
    check("neg_v", out_v, 32'h0);
    tick();
    send(16'h0003, 16'h0004, 32'h0000_0000, 32'h0001_0000, 32'h0002_0000);
    check("zero_recip_x", recip_x, 32'h0);
    wait_out("zero_wait");
    check("zero_u", out_u, 32'h0);
    check("zero_v", out_v, 32'h0);
    tick();

    // Overflow: (+/-)2^14 * 4.0 shifted leaves 2^32
    send(16'h0005, 16'h0006, 32'h0000_4000, 32'h4000_0000, 32'hC000_0000);
    check("ovf_recip_x", recip_x, 32'h0000_4000);
    wait_out("ovf_wait");
`ifdef PERSP_SAT_EN
    check("ovf_u", out_u, 32'h7FFF_FFFF);
    check("ovf_v", out_v, 32'h8000_0000);
`else
    check("ovf_u", out_u, 32'h0000_0000);
    check("ovf_v", out_v, 32'h0000_0000);
`endif
    tick();
    repeat (2) tick();

    // Reset mid-operation: two entries in the FIFO, two in flight
    out_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 4; i++) begin
      drive(16'h0300 + 16'(i), 16'h0400 + 16'(i), 32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
      if (in_ready) n_acc++;
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("mid_accepts",   n_acc,     4);
    check("mid_pre_valid", out_valid, 1'b1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid",    out_valid, 1'b0);
    check("mid_rst_recip_x",  recip_x,   32'h0);
    check("mid_rst_out_u",    out_u,     32'h0);
    check("mid_rst_in_ready", in_ready,  1'b1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("mid_no_stale", out_valid, 1'b0);
    end
    send(16'h0007, 16'h0008, 32'h0001_0000, 32'h0005_0000, 32'h0007_0000);
    check("mid_lat0", out_valid, 1'b0);
    tick();
    check("mid_lat1", out_valid, 1'b0);
    tick();
    check("mid_lat2", out_valid, 1'b0);
    tick();
    check("mid_lat3", out_valid, 1'b1);
    check("mid_x", out_x, 16'h0007);
    check("mid_u", out_u, 32'h0005_0000);
    check("mid_v", out_v, 32'h0007_0000);
    repeat (3) tick();
    check("final_q_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
